ds18b20_responder: RTL and testbench
====================================

# ds18b20_responder

One-wire slave that emulates a DS18B20 temperature sensor on an open-drain bus. It detects reset pulses, answers with a presence pulse, and decodes the Skip ROM command followed by the Convert T or Read Scratchpad function commands. On Read Scratchpad it serves a 9-byte scratchpad with Dallas CRC-8. It sits at the far end of the `one_wire` line from the DS18B20Z master, for board-to-board temperature forwarding and as the closed-loop bench partner for the master.

## Interface
- `CLK_MHZ`, default 12: system clock in MHz; sets the 1 µs tick divider.
- `CONV_US`, default 750000: conversion duration in µs; benches override it to a small value.
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous, active-high reset.
- `one_wire` inout 1: open-drain bus. The block only ever drives `1'b0` or `1'bz`; an external pull-up is present.
- `temp_in` input 16: two's-complement temperature, 1/16 °C per LSB. Latched into the scratchpad when a conversion completes.
- `conv_req` output 1: one-cycle pulse when a Convert T command byte completes.
- `presence` output 1: one-cycle pulse at the start of each presence pulse.
- `err` output 1: one-cycle pulse on an unsupported ROM or function command.

## Operation
- **Input path:** 2-flop synchronizer on `one_wire`, then falling- and rising-edge detect.
- **Tick:** µs counter from `CLK_MHZ`. All durations are counted in ticks after the synchronized edge.
- **Reset detect (any state):** a low lasting ≥480 µs aborts the current activity and enters RST_WAIT. The abort takes priority over every other state.
- **States and transitions:**
  - IDLE: wait for a ≥480 µs low.
  - RST_WAIT: wait for the rising edge.
  - PRES_DLY: wait 30 µs.
  - PRES: drive low 120 µs, then go to ROM_CMD.
  - ROM_CMD: receive 8 bits.
  - FUNC_CMD: receive 8 bits.
  - XMIT: send scratchpad bits.
  - CONV: answer read slots with conversion status.
  - HALT: ignore the bus until the next reset.
- **Write slot (receive):** on a falling edge, sample the bus 30 µs later. High = 1, low = 0. Bits arrive LSB first and are shifted into an 8-bit register.
- **ROM command:** 0xCC (Skip ROM) → FUNC_CMD. Any other value → `err` pulse, then HALT.
- **Function command 0x44:**
  - Pulse `conv_req`, load the conversion counter with `CONV_US`, enter CONV.
  - Read slots answer 0 while the counter is nonzero and 1 after it expires.
  - On expiry, `temp_in` is latched into scratchpad bytes 0–1 in the cycle the counter reaches 0.
- **Function command 0xBE:**
  - Enter XMIT and stream 72 bits, LSB first per byte.
  - Byte order: temp LSB, temp MSB, 0x4B (TH), 0x46 (TL), 0x7F (config), 0xFF, 0x0C, 0x10, CRC.
  - After byte 8 → HALT.
- **Other function command:** `err` pulse, then HALT.
- **Read slot (transmit):** on a falling edge, a 0 bit drives low 30 µs from edge detection. A 1 bit leaves the line released.
- **CRC:** Dallas CRC-8 (x⁸+x⁵+x⁴+1, reflected 0x8C). Computed serially over bytes 0–7 as they are shifted out, so byte 8 is ready with no gap.
- **Power-on scratchpad temperature:** 0x0550 (+85 °C) until the first conversion completes.
- **Master resets mid-conversion:** the conversion counter keeps running. The latch still occurs on expiry.

## Timing
- **Reset values:** `one_wire` = z; `conv_req`, `presence`, `err` = 0; state = IDLE; scratchpad temperature = 0x0550; conversion counter = 0.
- **Synchronizer latency:** 2 cycles from pad to detected edge. All µs windows start at the detected edge.
- **Driven lows:** presence = 120 µs ±1 tick; read-0 = 30 µs ±1 tick.
- **Release on `rst_in`:** assertion releases `one_wire` on the next clock edge, including during PRES and XMIT.
- **Counter sizing:** the conversion counter is wide enough for `CONV_US` at default (20 bits).

## Structure
- **Package `onewire_pkg`:** command constants (CMD_SKIP_ROM = 0xCC, CMD_CONVERT = 0x44, CMD_READ_SP = 0xBE), state enum, timing constants in µs (T_RST_MIN = 480, T_PDLY = 30, T_PRES = 120, T_SAMPLE = 30, T_RD0 = 30), fixed scratchpad bytes.
- **Sub-module `onewire_crc8`:** serial bit-in CRC-8 with clear and enable. Reused by the master side for CRC checking.

## Test plan
- **Reset/presence:** hold low 500 µs, then release → `presence` pulse; bus low starting 30 µs after release, for 120 µs.
- **Power-on read:** reset, write 0xCC then 0xBE, then 72 read slots → bytes 50 05 4B 46 7F FF 0C 10 1C.
- **Conversion:** `CONV_US` = 100, `temp_in` = 0x0191; send 0xCC, 0x44 → `conv_req` pulse; read slots return 0 for 100 µs, then 1. A following read of bytes 0–1 returns 91 01, and the CRC matches the bench model.
- **Unsupported ROM:** ROM command 0x33 → `err` pulse; no bus drive on the next 16 read slots until a new reset.
- **Abort:** a 480 µs low during byte 3 of XMIT → transmission aborts; presence follows the release; a fresh 0xCC/0xBE restarts from byte 0.
- **Local reset:** `rst_in` asserted mid-PRES → `one_wire` released next cycle; the scratchpad returns to 0x0550.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: command codes, state encoding, slot timing in µs,
// fixed DS18B20 scratchpad contents and the Dallas CRC-8 bit step.
package onewire_pkg;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  localparam int unsigned T_RST_MIN = 480;
  localparam int unsigned T_PDLY    = 30;
  localparam int unsigned T_PRES    = 120;
  localparam int unsigned T_SAMPLE  = 30;
  localparam int unsigned T_RD0     = 30;

  localparam int unsigned CONV_W = 20;
  localparam int unsigned US_W   = 10;
  localparam int unsigned WIN_W  = 8;

  localparam logic [15:0] TEMP_POR = 16'h0550;
  localparam logic [7:0]  SP_TH    = 8'h4B;
  localparam logic [7:0]  SP_TL    = 8'h46;
  localparam logic [7:0]  SP_CFG   = 8'h7F;
  localparam logic [7:0]  SP_RSV0  = 8'hFF;
  localparam logic [7:0]  SP_RSV1  = 8'h0C;
  localparam logic [7:0]  SP_RSV2  = 8'h10;
  localparam logic [7:0]  CRC_POLY = 8'h8C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_WAIT,
    ST_PRES_DLY,
    ST_PRES,
    ST_ROM_CMD,
    ST_FUNC_CMD,
    ST_XMIT,
    ST_CONV,
    ST_HALT
  } state_t;

  // Reflected CRC-8 step: data enters LSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return (crc >> 1) ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8 accumulator: one data bit per enable, synchronous clear.
module onewire_crc8 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);
  import onewire_pkg::*;

  logic [7:0] r_crc;

  always_ff @(posedge clk_in) begin
    if (rst_in || i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc8_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ds18b20_responder.sv
// DS18B20 emulator on an open-drain 1-Wire bus: reset/presence, Skip ROM,
// Convert T and Read Scratchpad with serially generated CRC-8.
module ds18b20_responder #(
  parameter int unsigned CLK_MHZ = 12,
  parameter int unsigned CONV_US = 750000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  inout  wire         one_wire,
  input  logic [15:0] temp_in,
  output logic        conv_req,
  output logic        presence,
  output logic        err
);
  import onewire_pkg::*;

  localparam int unsigned DIV_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

  logic              r_s1, r_s2, r_s3;
  logic [DIV_W-1:0]  r_div;
  logic [US_W-1:0]   r_low_us;
  logic [WIN_W-1:0]  r_us;
  state_t            r_state, w_state_nxt;
  logic              r_busy, r_drive;
  logic [7:0]        r_sh;
  logic [2:0]        r_bitcnt;
  logic [3:0]        r_byte;
  logic [15:0]       r_temp;
  logic [CONV_W-1:0] r_conv;

  logic w_fall, w_rise, w_tick, w_rst_det, w_slot_st, w_slot_start, w_win_done;
  logic w_conv_done, w_tx_bit;
  logic [WIN_W-1:0] w_win_len;
  logic [7:0] w_byte_in, w_tx_byte, w_crc;
  logic w_drive_nxt, w_pres_nxt, w_conv_nxt, w_err_nxt, w_conv_load;
  logic w_shift, w_tx_adv, w_crc_clr, w_crc_en;

  assign one_wire = r_drive ? 1'b0 : 1'bz;

  assign w_fall       = r_s3 & ~r_s2;
  assign w_rise       = ~r_s3 & r_s2;
  assign w_tick       = (r_div == DIV_W'(CLK_MHZ - 1));
  assign w_rst_det    = ~r_s2 & ~w_fall & (r_low_us == US_W'(T_RST_MIN));
  assign w_slot_st    = (r_state == ST_ROM_CMD) || (r_state == ST_FUNC_CMD) ||
                        (r_state == ST_XMIT) || (r_state == ST_CONV);
  assign w_slot_start = w_fall & ~r_busy & w_slot_st;
  assign w_win_len    = ((r_state == ST_XMIT) || (r_state == ST_CONV)) ?
                        WIN_W'(T_RD0 - 1) : WIN_W'(T_SAMPLE - 1);
  assign w_win_done   = r_busy & w_tick & (r_us == w_win_len);
  assign w_byte_in    = {r_s2, r_sh[7:1]};
  assign w_conv_done  = w_tick & (r_conv == CONV_W'(1));

  // Scratchpad byte currently being shifted out; byte 8 is the running CRC.
  always_comb begin
    case (r_byte)
      4'd0:    w_tx_byte = r_temp[7:0];
      4'd1:    w_tx_byte = r_temp[15:8];
      4'd2:    w_tx_byte = SP_TH;
      4'd3:    w_tx_byte = SP_TL;
      4'd4:    w_tx_byte = SP_CFG;
      4'd5:    w_tx_byte = SP_RSV0;
      4'd6:    w_tx_byte = SP_RSV1;
      4'd7:    w_tx_byte = SP_RSV2;
      default: w_tx_byte = w_crc;
    endcase
  end
  assign w_tx_bit = w_tx_byte[r_bitcnt];

  onewire_crc8 u_crc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_clr  (w_crc_clr),
    .i_en   (w_crc_en),
    .i_bit  (w_tx_bit),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drive_nxt = r_drive;
    w_pres_nxt  = 1'b0;
    w_conv_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_conv_load = 1'b0;
    w_shift     = 1'b0;
    w_tx_adv    = 1'b0;
    w_crc_clr   = 1'b0;
    w_crc_en    = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_RST_WAIT: begin
        w_drive_nxt = 1'b0;
        if (w_rise) w_state_nxt = ST_PRES_DLY;
      end
      ST_PRES_DLY: begin
        if (w_tick && r_us == WIN_W'(T_PDLY - 1)) begin
          w_state_nxt = ST_PRES;
          w_drive_nxt = 1'b1;
          w_pres_nxt  = 1'b1;
        end
      end
      ST_PRES: begin
        if (w_tick && r_us == WIN_W'(T_PRES - 1)) begin
          w_state_nxt = ST_ROM_CMD;
          w_drive_nxt = 1'b0;
        end
      end
      ST_ROM_CMD: begin
        if (w_win_done) begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'd7) begin
            if (w_byte_in == CMD_SKIP_ROM) begin
              w_state_nxt = ST_FUNC_CMD;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_HALT;
            end
          end
        end
      end
      ST_FUNC_CMD: begin
        if (w_win_done) begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'd7) begin
            if (w_byte_in == CMD_CONVERT) begin
              w_conv_nxt  = 1'b1;
              w_conv_load = 1'b1;
              w_state_nxt = ST_CONV;
            end else if (w_byte_in == CMD_READ_SP) begin
              w_crc_clr   = 1'b1;
              w_state_nxt = ST_XMIT;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_HALT;
            end
          end
        end
      end
      ST_XMIT: begin
        if (w_slot_start) w_drive_nxt = ~w_tx_bit;
        if (w_win_done) begin
          w_drive_nxt = 1'b0;
          w_tx_adv    = 1'b1;
          w_crc_en    = (r_byte != 4'd8);
          if (r_byte == 4'd8 && r_bitcnt == 3'd7) w_state_nxt = ST_HALT;
        end
      end
      ST_CONV: begin
        if (w_slot_start) w_drive_nxt = (r_conv != '0);
        if (w_win_done)   w_drive_nxt = 1'b0;
      end
      ST_HALT:  w_drive_nxt = 1'b0;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // A long low overrides whatever the bus was doing.
    if (w_rst_det) begin
      w_state_nxt = ST_RST_WAIT;
      w_drive_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_s3     <= 1'b1;
      r_div    <= '0;
      r_low_us <= '0;
      r_us     <= '0;
      r_busy   <= 1'b0;
      r_drive  <= 1'b0;
      r_sh     <= '0;
      r_bitcnt <= '0;
      r_byte   <= '0;
      r_temp   <= TEMP_POR;
      r_conv   <= '0;
      conv_req <= 1'b0;
      presence <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_s1 <= one_wire;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // µs prescaler realigns on every bus edge so windows start at the edge.
      if (w_fall || w_rise || w_tick) r_div <= '0;
      else                            r_div <= r_div + DIV_W'(1);
      if (w_fall) r_low_us <= '0;
      else if (~r_s2 && w_tick && r_low_us != US_W'(T_RST_MIN)) r_low_us <= r_low_us + US_W'(1);
      if (w_state_nxt != r_state || w_slot_start) r_us <= '0;
      else if (w_tick && r_us != '1)              r_us <= r_us + WIN_W'(1);
      if (w_state_nxt != r_state) r_busy <= 1'b0;
      else if (w_slot_start)      r_busy <= 1'b1;
      else if (w_win_done)        r_busy <= 1'b0;
      if (w_shift) r_sh <= w_byte_in;
      if (w_state_nxt != r_state) begin
        r_bitcnt <= '0;
        r_byte   <= '0;
      end else if (w_shift || w_tx_adv) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_tx_adv && r_bitcnt == 3'd7) r_byte <= r_byte + 4'd1;
      end
      // Conversion runs independently of the bus state, surviving master resets.
      if (w_conv_load)                r_conv <= CONV_W'(CONV_US);
      else if (w_tick && r_conv != '0) r_conv <= r_conv - CONV_W'(1);
      if (w_conv_done) r_temp <= temp_in;
      r_drive  <= w_drive_nxt;
      conv_req <= w_conv_nxt;
      presence <= w_pres_nxt;
      err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_ds18b20_responder.sv
// Directed bench: a behavioural 1-Wire master exercising the DS18B20 responder.
module tb_ds18b20_responder;

  localparam int unsigned TB_MHZ  = 2;
  localparam int unsigned TB_CONV = 100;
  localparam int HALF = 5;
  localparam int US   = 2 * HALF * TB_MHZ;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_drv;
  logic [15:0] temp;
  wire         one_wire;
  logic        conv_req, presence, err;

  pullup (one_wire);
  assign one_wire = m_drv ? 1'b0 : 1'bz;

  ds18b20_responder #(.CLK_MHZ(TB_MHZ), .CONV_US(TB_CONV)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .one_wire (one_wire),
    .temp_in  (temp),
    .conv_req (conv_req),
    .presence (presence),
    .err      (err)
  );

  always #HALF clk = ~clk;

  int  n_vec = 0;
  int  n_mis = 0;
  int  n_pres = 0;
  int  n_convreq = 0;
  int  n_errp = 0;
  time t_conv = 0;

  always @(negedge clk) begin
    if (presence) n_pres <= n_pres + 1;
    if (err)      n_errp <= n_errp + 1;
    if (conv_req) begin
      n_convreq <= n_convreq + 1;
      t_conv    <= $time;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [63:0] d);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  task automatic write_bit(input logic b);
    m_drv = 1'b1;
    if (b) begin #(6*US);  m_drv = 1'b0; #(64*US); end
    else   begin #(60*US); m_drv = 1'b0; #(10*US); end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_drv = 1'b1; #(2*US);
    m_drv = 1'b0; #(11*US);
    b = (one_wire === 1'b0) ? 1'b0 : 1'b1;
    #(52*US);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin read_bit(b); v[i] = b; end
  endtask

  // Reset pulse, then watch 200 µs for the presence pulse and its bus footprint.
  task automatic ow_reset(input string tag, input bit timing);
    int p0;
    time t_rel, t_lo, t_hi;
    bit seen_lo, seen_hi;
    m_drv = 1'b1; #(500*US);
    m_drv = 1'b0; t_rel = $time; p0 = n_pres;
    seen_lo = 1'b0; seen_hi = 1'b0; t_lo = 0; t_hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!seen_lo && one_wire === 1'b0) begin seen_lo = 1'b1; t_lo = $time; end
      else if (seen_lo && !seen_hi && one_wire !== 1'b0) begin seen_hi = 1'b1; t_hi = $time; end
    end
    chk({tag, "_presence_pulse"}, 32'(n_pres - p0), 32'd1);
    if (timing) begin
      chk({tag, "_pres_start_30us"},
          32'(seen_lo && (t_lo - t_rel) >= 29*US && (t_lo - t_rel) <= 34*US), 32'd1);
      chk({tag, "_pres_len_120us"},
          32'(seen_hi && (t_hi - t_lo) >= 117*US && (t_hi - t_lo) <= 124*US), 32'd1);
    end
  endtask

  logic [7:0]  rb [9];
  logic [7:0]  ex [9];
  logic [7:0]  v8;
  logic [15:0] v16;
  logic        b;
  int          c0, p0;

  initial begin
    rst = 1'b1; m_drv = 1'b0; temp = 16'h0000;
    repeat (4) @(negedge clk);
    chk("rst_conv_req", 32'(conv_req), 32'd0);
    chk("rst_presence", 32'(presence), 32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_bus_released", 32'(one_wire !== 1'b0), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Power-on scratchpad read
    ex[0] = 8'h50; ex[1] = 8'h05; ex[2] = 8'h4B; ex[3] = 8'h46; ex[4] = 8'h7F;
    ex[5] = 8'hFF; ex[6] = 8'h0C; ex[7] = 8'h10; ex[8] = 8'h1C;
    ow_reset("por", 1'b1);
    write_byte(8'hCC); write_byte(8'hBE);
    for (int i = 0; i < 9; i++) read_byte(rb[i]);
    for (int i = 0; i < 9; i++) chk($sformatf("por_byte%0d", i), 32'(rb[i]), 32'(ex[i]));
    read_byte(v8);
    chk("por_halt_after_crc", 32'(v8), 32'hFF);

    // Unsupported ROM command
    c0 = n_errp;
    ow_reset("badrom", 1'b0);
    write_byte(8'h33);
    chk("badrom_err_pulse", 32'(n_errp - c0), 32'd1);
    for (int i = 0; i < 16; i++) begin read_bit(b); v16[i] = b; end
    chk("badrom_no_drive", 32'(v16), 32'hFFFF);

    // Unsupported function command
    c0 = n_errp;
    ow_reset("badfn", 1'b0);
    write_byte(8'hCC); write_byte(8'h55);
    chk("badfn_err_pulse", 32'(n_errp - c0), 32'd1);
    read_byte(v8);
    chk("badfn_no_drive", 32'(v8), 32'hFF);

    // Abort during byte 3 of a scratchpad read
    ow_reset("abort_pre", 1'b0);
    write_byte(8'hCC); write_byte(8'hBE);
    for (int i = 0; i < 3; i++) read_byte(rb[i]);
    chk("abort_byte2", 32'(rb[2]), 32'h4B);
    for (int i = 0; i < 4; i++) read_bit(b);
    ow_reset("abort", 1'b1);
    write_byte(8'hCC); write_byte(8'hBE);
    read_byte(rb[0]); read_byte(rb[1]);
    chk("abort_restart_b0", 32'(rb[0]), 32'h50);
    chk("abort_restart_b1", 32'(rb[1]), 32'h05);

    // Conversion
    temp = 16'h0191;
    c0 = n_convreq;
    ow_reset("conv", 1'b0);
    write_byte(8'hCC); write_byte(8'h44);
    chk("conv_req_pulse", 32'(n_convreq - c0), 32'd1);
    read_bit(b);
    chk("conv_busy_reads_0", 32'(b), 32'd0);
    if ($time < t_conv + 110*US) #(t_conv + 110*US - $time);
    read_bit(b);
    chk("conv_done_reads_1", 32'(b), 32'd1);
    temp = 16'hA5A5;
    ex[0] = 8'h91; ex[1] = 8'h01;
    ex[8] = crc_model({ex[7], ex[6], ex[5], ex[4], ex[3], ex[2], ex[1], ex[0]});
    ow_reset("conv_rd", 1'b0);
    write_byte(8'hCC); write_byte(8'hBE);
    for (int i = 0; i < 9; i++) read_byte(rb[i]);
    for (int i = 0; i < 9; i++) chk($sformatf("conv_byte%0d", i), 32'(rb[i]), 32'(ex[i]));

    // Local reset in the middle of a presence pulse
    m_drv = 1'b1; #(500*US);
    m_drv = 1'b0; p0 = n_pres;
    for (int i = 0; i < 200 && n_pres == p0; i++) @(negedge clk);
    chk("lrst_presence_seen", 32'(n_pres - p0), 32'd1);
    repeat (40) @(negedge clk);
    chk("lrst_bus_low_in_pres", 32'(one_wire === 1'b0), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("lrst_release_next_edge", 32'(one_wire !== 1'b0), 32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    ow_reset("lrst", 1'b0);
    write_byte(8'hCC); write_byte(8'hBE);
    read_byte(rb[0]); read_byte(rb[1]);
    chk("lrst_temp_lsb", 32'(rb[0]), 32'h50);
    chk("lrst_temp_msb", 32'(rb[1]), 32'h05);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
